// File: rtl/viterbi_dec_1_2.sv
// Hard-decision rate-1/2 Viterbi decoder for tail-terminated frames.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/in_sym/in_last
//   symbol stream; out_valid/out_ready/out_bit/out_last decoded bits;
//   frame_err pulses when a frame is cut at FRAME_MAX symbols.
module viterbi_dec_1_2 #(
    parameter int         K         = 4,
    parameter logic [7:0] G0_OCT    = 8'o17,
    parameter logic [7:0] G1_OCT    = 8'o13,
    parameter int         FRAME_MAX = 64,
    parameter int         PM_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_sym,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last,
    output logic       frame_err
);
    localparam int M  = K - 1;
    localparam int S  = 1 << M;
    localparam int CW = $clog2(FRAME_MAX + 1);
    localparam int IW = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

    localparam logic [1:0] ST_ACS   = 2'd0;
    localparam logic [1:0] ST_TRACE = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [K-1:0]    G0      = G0_OCT[K-1:0];
    localparam logic [K-1:0]    G1      = G1_OCT[K-1:0];
    localparam logic [CW-1:0]   M_C     = CW'(M);
    localparam logic [CW-1:0]   M1_C    = CW'(M + 1);
    localparam logic [CW-1:0]   LAST_C  = CW'(FRAME_MAX - 1);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W - 1){1'b0}}};

    function automatic logic [1:0] branch_metric(
        input logic [K-1:0] r,
        input logic [1:0]   rx
    );
        logic [1:0] d;
        d = {^(r & G0), ^(r & G1)} ^ rx;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(
        input logic [PM_W-1:0] a,
        input logic [1:0]      b
    );
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W - 1){1'b0}}, b};
        return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
    endfunction

    logic [1:0]      state_q, state_d;
    logic [PM_W-1:0] pm_q   [S];
    logic [PM_W-1:0] pm_new [S];
    logic [PM_W-1:0] pm_min;
    logic [S-1:0]    surv_bits;
    logic [S-1:0]    surv_mem [FRAME_MAX];
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   tidx_q;
    logic [CW-1:0]   oidx_q;
    logic [M-1:0]    tst_q;
    logic [FRAME_MAX-1:0] dec_q;
    logic            out_valid_q;
    logic            ferr_q;
    logic            acc;
    logic            last_sym;
    logic            surv_rd;

    assign in_ready  = rst_n & (state_q == ST_ACS);
    assign acc       = in_valid & in_ready;
    // Hitting the frame limit closes the frame as if in_last were set.
    assign last_sym  = in_last | (cnt_q == LAST_C);
    assign surv_rd   = surv_mem[tidx_q[IW-1:0]][tst_q];
    assign out_valid = out_valid_q;
    assign out_bit   = out_valid_q & dec_q[oidx_q[IW-1:0]];
    assign out_last  = out_valid_q & (oidx_q == (cnt_q - M1_C));
    assign frame_err = ferr_q;

    // State n = {p[M-2:0], b}: its predecessors differ only in the
    // bit shifted out, so the encoder register is {0/1, n}.
    for (genvar g = 0; g < S; g++) begin : g_acs
        localparam logic [M-1:0] ST = M'(g);
        logic [PM_W-1:0] s0, s1;
        assign s0 = sat_add(pm_q[{1'b0, ST[M-1:1]}],
                            branch_metric({1'b0, ST}, in_sym));
        assign s1 = sat_add(pm_q[{1'b1, ST[M-1:1]}],
                            branch_metric({1'b1, ST}, in_sym));
        assign surv_bits[g] = (s1 < s0);
        assign pm_new[g]    = (s1 < s0) ? s1 : s0;
    end

    always_comb begin
        pm_min = pm_new[0];
        for (int i = 1; i < S; i++) begin
            if (pm_new[i] < pm_min) pm_min = pm_new[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACS:   if (acc && last_sym) state_d = ST_TRACE;
            ST_TRACE: if (tidx_q == '0)
                          state_d = (cnt_q > M_C) ? ST_OUT : ST_ACS;
            ST_OUT:   if (out_ready && out_last) state_d = ST_ACS;
            default:  state_d = ST_ACS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc) surv_mem[cnt_q[IW-1:0]] <= surv_bits;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACS;
            cnt_q       <= '0;
            tidx_q      <= '0;
            oidx_q      <= '0;
            tst_q       <= '0;
            dec_q       <= '0;
            out_valid_q <= 1'b0;
            ferr_q      <= 1'b0;
            for (int i = 0; i < S; i++)
                pm_q[i] <= (i == 0) ? '0 : PM_INIT;
        end else begin
            state_q <= state_d;
            ferr_q  <= 1'b0;
            unique case (state_q)
                ST_ACS: begin
                    if (acc) begin
                        for (int i = 0; i < S; i++)
                            pm_q[i] <= pm_new[i] - pm_min;
                        cnt_q <= cnt_q + ONE_C;
                        if (last_sym) begin
                            tidx_q <= cnt_q;
                            tst_q  <= '0;
                            ferr_q <= ~in_last;
                        end
                    end
                end
                ST_TRACE: begin
                    dec_q[tidx_q[IW-1:0]] <= tst_q[0];
                    tst_q  <= {surv_rd, tst_q[M-1:1]};
                    tidx_q <= tidx_q - ONE_C;
                    if (tidx_q == '0) begin
                        if (cnt_q > M_C) begin
                            out_valid_q <= 1'b1;
                            oidx_q      <= '0;
                        end else begin
                            cnt_q <= '0;
                            for (int i = 0; i < S; i++)
                                pm_q[i] <= (i == 0) ? '0 : PM_INIT;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid_q <= 1'b0;
                            cnt_q       <= '0;
                            for (int i = 0; i < S; i++)
                                pm_q[i] <= (i == 0) ? '0 : PM_INIT;
                        end else begin
                            oidx_q <= oidx_q + ONE_C;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/viterbi_dec_1_2.md
VITERBI_DEC_1_2 -- requirements
Module: viterbi_dec_1_2

Interface
REQ-001 Parameter K, default 4: constraint length (3..7); M = K-1, S = 2^M states.
REQ-002 Parameter G0_OCT, default 8'o17: generator for c0, octal, LSB = current input bit.
REQ-003 Parameter G1_OCT, default 8'o13: generator for c1, same convention.
REQ-004 Parameter FRAME_MAX, default 64: maximum symbols per frame, tail included.
REQ-005 Parameter PM_W, default 8: path-metric width, unsigned.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  synchronous reset, active low.
REQ-008 in_valid  in  1  in_sym/in_last valid.
REQ-009 in_ready  out  1  decoder accepts a symbol; transfer = in_valid & in_ready.
REQ-010 in_sym  in  2  hard-decision received symbol {c0, c1}.
REQ-011 in_last  in  1  marks last symbol of frame (last tail symbol).
REQ-012 out_valid  out  1  out_bit/out_last valid.
REQ-013 out_ready  in  1  sink accepts; transfer = out_valid & out_ready.
REQ-014 out_bit  out  1  decoded information bit, in original order.
REQ-015 out_last  out  1  marks last decoded bit of frame.
REQ-016 frame_err  out  1  one-cycle pulse on forced frame termination (REQ-027).

Function
REQ-017 Code model: encoder state p advances to {p[M-2:0], b}; expected symbol for (p, b) is {^({p,b} & G0 mask), ^({p,b} & G1 mask)}; tail-terminated from and to state 0.
REQ-018 FSM states ACS, TRACE, OUT; in_ready = 1 only in ACS and out of reset.
REQ-019 ACS: one accepted symbol per cycle; all S states updated in parallel in that cycle.
REQ-020 Branch metric = Hamming distance (0..2) between in_sym and expected symbol.
REQ-021 For next state n, predecessors are {0, n[M-1:1]} and {1, n[M-1:1]}; pick smaller metric sum; tie selects the 0 predecessor; store the chosen leading bit as survivor bit for (symbol index, n).
REQ-022 Normalization: after each update, subtract the minimum new metric from all metrics; sums saturate at 2^PM_W-1.
REQ-023 Frame start metrics: state 0 = 0, all others = 2^(PM_W-1); symbol counter N = 0.
REQ-024 Accepted symbol with in_last = 1 (N symbols total) moves ACS -> TRACE next cycle.
REQ-025 TRACE: starts at state 0, exactly N cycles, newest symbol first; each cycle record decoded bit = state[0], then state <= {survivor, state[M-1:1]}.
REQ-026 OUT: presents decoded bits 0..N-M-1 in order; out_last = 1 on bit N-M-1; holds out_bit/out_last stable while out_valid & !out_ready; after last transfer -> ACS with REQ-023 metrics.
REQ-027 Counter reaching FRAME_MAX without in_last: that symbol is treated as last; frame_err pulses one cycle with the TRACE transition.
REQ-028 N <= M: no bits output; TRACE -> ACS directly, out_valid never asserts.
REQ-029 in_sym values are taken as given; no erasure support.

Reset
REQ-030 rst_n = 0 at a clock edge: FSM -> ACS, metrics per REQ-023, counters 0, out_valid = 0, out_bit = 0, out_last = 0, frame_err = 0, in_ready = 0 while rst_n = 0.
REQ-031 Reset mid-frame (any state) aborts the frame; no partial output after rst_n returns to 1.
REQ-032 in_ready = 1 on the first cycle after rst_n returns to 1; survivor memory needs no reset.

Verification
REQ-033 K=3, G0=7, G1=5; symbols 11,10,00,01,01,11, in_last on the 6th -> out bits 1,0,1,1, out_last on the 4th, frame_err = 0.
REQ-034 Same frame, 3rd symbol flipped to 10 -> identical output 1,0,1,1 (single-error correction).
REQ-035 Same frame, out_ready toggled 1,0,0,1,... -> no bit lost or duplicated; in_ready = 0 until out_last transfers.
REQ-036 Default K=4 (17,13); 64 symbols, no in_last -> frame_err pulses once, 61 bits output, in_ready returns to 1.
REQ-037 rst_n low for 1 cycle during the 3rd OUT beat -> out_valid = 0 next cycle; a following clean frame decodes correctly.
REQ-038 Two-symbol frame at K=3 (N = M) -> no out_valid; next frame decodes normally.
